// File: rtl/cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter: round-robin sharing of the external CPU bus between the
// load/store engine (port 0) and DMA/video fetch (port 1); owns strobe timing.
// Optional ACTIVE-state watchdog: define BUS_ARB_TIMEOUT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_r0_req,
  input  logic              i_r0_we,
  input  logic [ADDR_W-1:0] i_r0_addr,
  input  logic [DATA_W-1:0] i_r0_wdata,
  output logic              o_r0_done,
  input  logic              i_r1_req,
  input  logic              i_r1_we,
  input  logic [ADDR_W-1:0] i_r1_addr,
  input  logic [DATA_W-1:0] i_r1_wdata,
  output logic              o_r1_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err,
  output logic              o_grant,
  output logic              o_busy,
  output logic              o_bus_clk,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_data,
  input  logic [DATA_W-1:0] i_bus_data,
  input  logic              i_bus_data_ready
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t              r_state, w_state_nxt;
  logic                r_last_grant, w_last_grant_nxt;
  logic                r_grant, w_grant_nxt;
  logic                r_bus_clk, w_bus_clk_nxt;
  logic                r_bus_we, w_bus_we_nxt;
  logic [ADDR_W-1:0]   r_bus_addr, w_bus_addr_nxt;
  logic [DATA_W-1:0]   r_bus_data, w_bus_data_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_done0, w_done0_nxt;
  logic                r_done1, w_done1_nxt;
  logic                w_win;

  // Both requesting: the port that did not win last time goes next.
  assign w_win = (i_r0_req && i_r1_req) ? ~r_last_grant : i_r1_req;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;
  logic             w_timeout;

  // r_cnt holds the number of wait cycles already spent in ACTIVE.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_err     = r_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end
`else
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_bus_clk    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_data   <= '0;
      r_rdata      <= '0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_grant      <= w_grant_nxt;
      r_bus_clk    <= w_bus_clk_nxt;
      r_bus_we     <= w_bus_we_nxt;
      r_bus_addr   <= w_bus_addr_nxt;
      r_bus_data   <= w_bus_data_nxt;
      r_rdata      <= w_rdata_nxt;
      r_done0      <= w_done0_nxt;
      r_done1      <= w_done1_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_grant_nxt      = r_grant;
    w_bus_clk_nxt    = r_bus_clk;
    w_bus_we_nxt     = r_bus_we;
    w_bus_addr_nxt   = r_bus_addr;
    w_bus_data_nxt   = r_bus_data;
    w_rdata_nxt      = r_rdata;
    w_done0_nxt      = 1'b0;
    w_done1_nxt      = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    w_cnt_nxt        = r_cnt;
    w_err_nxt        = r_err;
`endif
    case (r_state)
      ST_IDLE: begin
        w_bus_clk_nxt = 1'b0;
        if (i_r0_req || i_r1_req) begin
          w_bus_clk_nxt    = 1'b1;
          w_grant_nxt      = w_win;
          w_last_grant_nxt = w_win;
          w_bus_we_nxt     = w_win ? i_r1_we    : i_r0_we;
          w_bus_addr_nxt   = w_win ? i_r1_addr  : i_r0_addr;
          w_bus_data_nxt   = w_win ? i_r1_wdata : i_r0_wdata;
          w_state_nxt      = ST_ACTIVE;
`ifdef BUS_ARB_TIMEOUT_EN
          w_cnt_nxt        = '0;
`endif
        end
      end
      ST_ACTIVE: begin
        if (i_bus_data_ready) begin
          w_bus_clk_nxt = 1'b0;
          if (!r_bus_we) w_rdata_nxt = i_bus_data;
          w_done0_nxt   = ~r_grant;
          w_done1_nxt   = r_grant;
          w_state_nxt   = ST_RELEASE;
`ifdef BUS_ARB_TIMEOUT_EN
          w_err_nxt     = 1'b0;
        end else if (w_timeout) begin
          w_bus_clk_nxt = 1'b0;
          w_rdata_nxt   = '1;
          w_err_nxt     = 1'b1;
          w_done0_nxt   = ~r_grant;
          w_done1_nxt   = r_grant;
          w_state_nxt   = ST_RELEASE;
        end else begin
          w_cnt_nxt     = r_cnt + 1'b1;
`endif
        end
      end
      ST_RELEASE: begin
        if (!i_bus_data_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_r0_done  = r_done0;
  assign o_r1_done  = r_done1;
  assign o_rdata    = r_rdata;
  assign o_grant    = r_grant;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_bus_clk  = r_bus_clk;
  assign o_bus_we   = r_bus_we;
  assign o_bus_addr = r_bus_addr;
  assign o_bus_data = r_bus_data;

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: scoreboard of expected completions
// popped on each done pulse, plus inline checks of bus strobe timing.
`default_nettype none

module tb_cpu_bus_arbiter;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
  logic        r0_done, r1_done, err, grant, busy, bus_clk, bus_we;
  logic [31:0] rdata, bus_addr, bus_data;
  logic [31:0] bus_rdata = 0;
  logic        ready = 0;

  cpu_bus_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_r0_req(r0_req), .i_r0_we(r0_we), .i_r0_addr(r0_addr), .i_r0_wdata(r0_wdata), .o_r0_done(r0_done),
    .i_r1_req(r1_req), .i_r1_we(r1_we), .i_r1_addr(r1_addr), .i_r1_wdata(r1_wdata), .o_r1_done(r1_done),
    .o_rdata(rdata), .o_err(err), .o_grant(grant), .o_busy(busy),
    .o_bus_clk(bus_clk), .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_data(bus_data),
    .i_bus_data(bus_rdata), .i_bus_data_ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        grant;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_rdata = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic g, input logic [31:0] rd, input logic e);
    exp_t x;
    x.grant = g; x.rdata = rd; x.err = e;
    sb.push_back(x);
    m_rdata = rd;
  endtask

  task automatic wait_clk(input logic v, input int budget, input string tag);
    int n = 0;
    while (bus_clk !== v && n < budget) begin
      tick;
      n++;
    end
    check(tag, bus_clk, v);
  endtask

  task automatic do_reset;
    rst = 1; r0_req = 0; r1_req = 0; ready = 0;
    tick; tick;
    rst = 0;
    m_rdata = 0;
  endtask

  // One single-port transfer; ready rises after wait_cyc extra ACTIVE cycles.
  task automatic xfer(input int port, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd, input int wait_cyc);
    if (port == 0) begin r0_req = 1; r0_we = we; r0_addr = addr; r0_wdata = wd; end
    else           begin r1_req = 1; r1_we = we; r1_addr = addr; r1_wdata = wd; end
    push(port[0], we ? m_rdata : rd, 1'b0);
    tick;
    check("grant_latency", bus_clk, 1);
    check("grant", grant, port[0]);
    r0_req = 0; r1_req = 0;
    r0_addr = ~addr; r1_addr = ~addr; r0_wdata = ~wd; r1_wdata = ~wd;
    check("bus_addr", bus_addr, addr);
    check("bus_data", bus_data, wd);
    check("bus_we", bus_we, we);
    for (int i = 0; i < wait_cyc; i++) begin
      tick;
      check("bus_clk_held", bus_clk, 1);
      check("bus_addr_stable", bus_addr, addr);
      check("bus_data_stable", bus_data, wd);
    end
    ready = 1; bus_rdata = rd;
    tick;
    check("bus_clk_fall", bus_clk, 0);
    check("release_busy", busy, 1);
    ready = 0; bus_rdata = 32'hDEAD_BEEF;
    tick;
    check("back_to_idle", busy, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (r0_done === 1'b1 || r1_done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {r1_done, r0_done}, 0);
      end else begin
        e = sb.pop_front();
        check("done_port", {r1_done, r0_done}, e.grant ? 2'b10 : 2'b01);
        check("done_grant", grant, e.grant);
        check("done_rdata", rdata, e.rdata);
        check("done_err", err, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    tick;
    check("rst_bus_clk", bus_clk, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", err, 0);
    check("rst_dones", {r1_done, r0_done}, 0);
    check("rst_bus", {bus_we, bus_addr, bus_data}, 0);
    rst = 0; m_rdata = 0;

    // port 0 read, strobe held 3 cycles
    xfer(0, 1'b0, 32'h0000_1234, 32'hCAFE_0000, 32'h0000_00A5, 2);
    check("rdata_held", rdata, 32'h0000_00A5);
    // port 1 write leaves rdata untouched
    xfer(1, 1'b1, 32'h0000_2000, 32'h0000_005A, 32'h7777_7777, 1);
    check("rdata_after_write", rdata, 32'h0000_00A5);
    // minimum-length transfer
    xfer(1, 1'b0, 32'h0000_3000, 32'h0, 32'h1357_9BDF, 0);

    // both held from reset: grants alternate 0,1,0,1
    do_reset;
    r0_req = 1; r0_we = 0; r0_addr = 32'h100;
    r1_req = 1; r1_we = 0; r1_addr = 32'h200;
    for (int k = 0; k < 4; k++) push(k[0], 32'h1000 + k, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_clk(1, 10, "rr_start");
      check("rr_grant", grant, k[0]);
      check("rr_addr", bus_addr, k[0] ? 32'h200 : 32'h100);
      tick;
      ready = 1; bus_rdata = 32'h1000 + k;
      tick;
      check("rr_clk_fall", bus_clk, 0);
      if (k == 3) begin r0_req = 0; r1_req = 0; end
      ready = 0;
      tick;
      check("rr_idle_gap", busy, 0);
    end

    // ready held high after completion keeps the arbiter in RELEASE
    r0_req = 1; r0_addr = 32'h300;
    push(1'b0, 32'h3300, 1'b0);
    push(1'b0, 32'h4400, 1'b0);
    wait_clk(1, 10, "hold_start");
    ready = 1; bus_rdata = 32'h3300;
    tick;
    check("hold_fall", bus_clk, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("hold_busy", busy, 1);
      check("hold_noclk", bus_clk, 0);
    end
    ready = 0; bus_rdata = 32'h4400;
    tick;
    check("hold_idle", busy, 0);
    tick;
    check("hold_regrant", bus_clk, 1);
    check("hold_regrant_port", grant, 0);
    r0_req = 0;
    ready = 1;
    tick;
    ready = 0;
    tick;
    check("hold_done_idle", busy, 0);

    // asynchronous reset mid-ACTIVE
    r0_req = 1; r0_addr = 32'h500; r0_we = 0;
    tick;
    check("abort_active", bus_clk, 1);
    r0_req = 0;
    #2 rst = 1;
    #1;
    check("abort_clk", bus_clk, 0);
    check("abort_busy", busy, 0);
    check("abort_outs", {grant, err, r1_done, r0_done, rdata}, 0);
    tick; tick;
    rst = 0; m_rdata = 0;
    r0_req = 1; r0_addr = 32'h600; r1_req = 1; r1_addr = 32'h700;
    push(1'b0, 32'h66, 1'b0);
    wait_clk(1, 10, "post_rst_start");
    check("post_rst_grant", grant, 0);
    r0_req = 0; r1_req = 0;
    ready = 1; bus_rdata = 32'h66;
    tick;
    ready = 0;
    tick;
    check("post_rst_idle", busy, 0);

    // ready never asserted
    r0_req = 1; r0_addr = 32'h800; r0_we = 0;
    tick;
    check("stall_start", bus_clk, 1);
    r0_req = 0;
`ifdef BUS_ARB_TIMEOUT_EN
    begin
      int n = 0;
      push(1'b0, 32'hFFFF_FFFF, 1'b1);
      while (bus_clk === 1'b1 && n < TO + 50) begin
        tick;
        n++;
      end
      check("timeout_cycles", n, TO);
      tick;
      check("timeout_idle", busy, 0);
    end
`else
    repeat (TO + 45) tick;
    check("stall_clk", bus_clk, 1);
    check("stall_busy", busy, 1);
    check("stall_err", err, 0);
    push(1'b0, 32'h88, 1'b0);
    ready = 1; bus_rdata = 32'h88;
    tick;
    ready = 0;
    tick;
    check("stall_idle", busy, 0);
`endif

    tick; tick;
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Sequences the CPU's external bus handshake (o_bus_clk / o_bus_we / o_bus_addr / o_bus_data / i_bus_data_ready).
- Shares that bus between two requesters: port 0 is the CPU load/store engine; port 1 is a DMA/video fetch engine.
- Sits between the cpu core and the bus fabric, and owns all bus-strobe timing.
- Round-robin arbitration; one transfer in flight at a time.

Parameters:
- ADDR_W, 32, bus address width (matches the codebase's wide-bus width).
- DATA_W, 32, bus data width.
- TIMEOUT_CYCLES, 255, ACTIVE-state watchdog limit. Used only when BUS_ARB_TIMEOUT_EN is defined. Must be at least 1.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_r0_req  in  1  port 0 request, level.
- i_r0_we  in  1  port 0 write enable (1 = write).
- i_r0_addr  in  ADDR_W  port 0 address.
- i_r0_wdata  in  DATA_W  port 0 write data.
- o_r0_done  out  1  port 0 transfer complete, 1-cycle pulse.
- i_r1_req, i_r1_we, i_r1_addr, i_r1_wdata, o_r1_done  same as port 0, for port 1.
- o_rdata  out  DATA_W  read data; valid in the done cycle and held until the next done.
- o_err  out  1  transfer aborted by timeout; valid with done.
- o_grant  out  1  index of the port owning the current or last transfer.
- o_busy  out  1  high in every state except IDLE.
- o_bus_clk  out  1  bus strobe.
- o_bus_we  out  1  bus write enable.
- o_bus_addr  out  ADDR_W  bus address.
- o_bus_data  out  DATA_W  bus write data.
- i_bus_data  in  DATA_W  bus read data.
- i_bus_data_ready  in  1  bus acknowledge.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - State = IDLE; last_grant = 1.
  - All outputs = 0: o_bus_clk, o_bus_we, o_bus_addr, o_bus_data, o_rdata, o_r0_done, o_r1_done, o_err, o_grant, o_busy.
  - Any aborted transfer produces no done pulse.
- States: IDLE, ACTIVE, RELEASE.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one request high: grant it.
  - Both high: grant the port opposite last_grant. After reset, port 0 wins first.
  - On grant, at the next edge: latch addr, we and wdata onto the o_bus_* outputs; o_bus_clk = 1; o_grant = winner; last_grant = winner; go to ACTIVE.
  - Latency from req to o_bus_clk rising is 1 cycle.
  - IDLE with no request: outputs hold their previous addr/data values; o_bus_clk = 0.
- ACTIVE:
  - o_bus_clk held at 1; addr, data and we are stable for the whole state.
  - When i_bus_data_ready is sampled 1, at the next edge:
    - o_bus_clk = 0.
    - If o_bus_we = 0, o_rdata = i_bus_data as sampled.
    - Pulse o_rN_done for the granted port; o_err = 0.
    - Go to RELEASE.
- RELEASE:
  - Waits for i_bus_data_ready = 0, then returns to IDLE at the next edge. Minimum 1 cycle.
  - Requests are ignored here, so a requester that drops req on the edge it sees done is never re-granted.
- Minimum transfer: 3 cycles from grant to IDLE, with ready asserted in the first ACTIVE cycle.
- Back-to-back transfers:
  - A requester that holds req through RELEASE is re-arbitrated in IDLE.
  - Round-robin guarantees that with both ports held high, grants alternate 0, 1, 0, 1.
- Other rules:
  - Requester signals are don't-care while their req is low.
  - req dropped during ACTIVE does not cancel the transfer; it completes and done still pulses.
  - o_bus_data is driven for reads too (latched wdata), but the bus ignores it when we = 0.
  - o_err = 0 always when the optional feature is absent.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to ACTIVE and increments each ACTIVE cycle without ready.
  - When the count reaches TIMEOUT_CYCLES with ready still 0, at the next edge: o_bus_clk = 0, o_rdata = all ones, o_err = 1, done pulses for the granted port, go to RELEASE.
  - RELEASE then waits for ready low as normal.
  - Ready and timeout in the same cycle: ready wins; o_err = 0.
- Undefined:
  - No counter; ACTIVE waits indefinitely; o_err tied 0; TIMEOUT_CYCLES unused.

Test Plan:
- Port 0 read at 0x0000_1234, ready high 2 cycles after o_bus_clk rises with i_bus_data = 0x0000_00A5 -> o_bus_clk high 3 cycles, o_r0_done pulses once, o_rdata = 0x0000_00A5, o_err = 0, o_grant = 0.
- Port 1 write: addr 0x0000_2000, wdata 0x0000_005A -> o_bus_we = 1, o_bus_addr = 0x0000_2000, o_bus_data = 0x0000_005A stable while o_bus_clk = 1; o_r1_done pulses; o_rdata unchanged.
- Both req held high from reset, 4 transfers, ready after 1 cycle each -> grant order 0, 1, 0, 1; no overlap of o_bus_clk windows; RELEASE lasts at least 1 cycle between transfers.
- Ready held high after completion for 3 cycles -> stays in RELEASE 3 cycles; no new o_bus_clk until ready falls, even with req high.
- i_rst asserted mid-ACTIVE (between edges) -> o_bus_clk and o_busy drop immediately; no done pulse; next request with both high grants port 0.
- With BUS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4, ready never asserted -> o_bus_clk falls after the 4 wait cycles; done pulses with o_err = 1 and o_rdata = 0xFFFF_FFFF. Without the macro -> bus stays in ACTIVE, o_bus_clk stays high, o_err = 0.
